count_display_ctrl: RTL and testbench

Run/stop/step controller for the 8-bit free-running counter datapath and its seven-segment display.
- Debounces two push-buttons and sequences the counter through a stop/run/single-step FSM.
- Paces counting with a prescaler tick.
- Time-multiplexes the two hex nibbles of the count onto one 4-bit digit bus, which feeds the existing seg7 decoder.

---
 rtl/count_display_ctrl_if.sv | 23 ++
 rtl/count_display_ctrl.sv | 178 +++++++++++++++++
 tb/tb_count_display_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/count_display_ctrl_if.sv
// Button/control inputs and counter/display outputs of count_display_ctrl.
// The master side drives buttons and controls; the slave side is the controller.
interface count_display_ctrl_if;
  logic       btn_start_stop;
  logic       btn_step;
  logic       dir;
  logic       clr;
  logic [7:0] count;
  logic [3:0] digit;
  logic [1:0] digit_sel;
  logic       running;
  logic       tick;

  modport master (
    output btn_start_stop, btn_step, dir, clr,
    input  count, digit, digit_sel, running, tick
  );

  modport slave (
    input  btn_start_stop, btn_step, dir, clr,
    output count, digit, digit_sel, running, tick
  );
endinterface

// File: rtl/count_display_ctrl.sv
// Run/stop/step controller for an 8-bit counter with a two-digit multiplexed hex display.
// Optional COUNT_AUTOSTOP_EN: run mode stops at FF (up) or 00 (down) instead of wrapping.
module count_display_ctrl #(
  parameter int PRESCALE_MAX = 9999,
  parameter int DEB_CYCLES   = 255,
  parameter int SCAN_DIV     = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  count_display_ctrl_if.slave  bus
);

  localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam int DW = (DEB_CYCLES > 0)   ? $clog2(DEB_CYCLES + 1)   : 1;
  localparam int SW = (SCAN_DIV > 0)     ? $clog2(SCAN_DIV + 1)     : 1;

  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALE_MAX);
  localparam logic [DW-1:0] DEB_TOP   = DW'(DEB_CYCLES);
  localparam logic [SW-1:0] SCAN_TOP  = SW'(SCAN_DIV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // Bit 0 = start/stop button, bit 1 = step button.
  logic [1:0]    btn_raw_s;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    deb_q;
  logic [1:0]    deb_dly_q;
  logic [DW-1:0] deb_cnt_q [2];
  logic [1:0]    press_s;

  state_e        state_q;
  logic          running_q;
  logic [7:0]    count_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    count_d;
  logic          tick_s;
`ifdef COUNT_AUTOSTOP_EN
  logic          at_term_s;
`endif

  logic [SW-1:0] scan_q;
  logic [1:0]    sel_q;

  assign btn_raw_s = {bus.btn_step, bus.btn_start_stop};
  assign press_s   = deb_q & ~deb_dly_q;

  // Synchronize, debounce and edge-detect both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      deb_q     <= 2'b00;
      deb_dly_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= {DW{1'b0}};
      end
    end else begin
      sync1_q   <= btn_raw_s;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= {DW{1'b0}};
        end else if (deb_cnt_q[i] == DEB_TOP) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= {DW{1'b0}};
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1'b1);
        end
      end
    end
  end

  // Candidate next count for a tick or step, plus the run-mode tick.
  always_comb begin
    if (bus.dir) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q + 8'd1;
    end
    tick_s = (state_q == ST_RUN) && (presc_q == PRESC_TOP);
  end

`ifdef COUNT_AUTOSTOP_EN
  // Terminal value reached in the current direction.
  always_comb begin
    if (bus.dir) begin
      at_term_s = (count_q == 8'h00);
    end else begin
      at_term_s = (count_q == 8'hFF);
    end
  end
`endif

  // Run/stop/step FSM with prescaler and counter; clr overrides any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      count_q   <= 8'h00;
      presc_q   <= {PW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_q <= {PW{1'b0}};
          if (press_s[0]) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end else if (press_s[1]) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            presc_q <= {PW{1'b0}};
`ifdef COUNT_AUTOSTOP_EN
            if (at_term_s) begin
              state_q   <= ST_IDLE;
              running_q <= 1'b0;
            end else begin
              count_q <= count_d;
            end
`else
            count_q <= count_d;
`endif
          end else begin
            presc_q <= presc_q + PW'(1'b1);
          end
          // A stop press overrides prescaler progress; step presses are ignored here.
          if (press_s[0]) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            presc_q   <= {PW{1'b0}};
          end
        end
        ST_STEP: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          count_q   <= count_d;
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          presc_q   <= {PW{1'b0}};
        end
      endcase
      if (bus.clr) begin
        count_q <= 8'h00;
        presc_q <= {PW{1'b0}};
      end
    end
  end

  // Free-running digit scan; the select flips each time the dwell counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= {SW{1'b0}};
      sel_q  <= 2'b01;
    end else if (scan_q == SCAN_TOP) begin
      scan_q <= {SW{1'b0}};
      sel_q  <= {sel_q[0], sel_q[1]};
    end else begin
      scan_q <= scan_q + SW'(1'b1);
    end
  end

  assign bus.count     = count_q;
  assign bus.running   = running_q;
  assign bus.tick      = tick_s;
  assign bus.digit_sel = sel_q;
  assign bus.digit     = sel_q[1] ? count_q[7:4] : count_q[3:0];

endmodule

// File: tb/tb_count_display_ctrl.sv
// Table-driven, scoreboard-checked bench for count_display_ctrl (small parameters).
module tb_count_display_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   since_rst;

  count_display_ctrl_if bus ();

  count_display_ctrl #(
    .PRESCALE_MAX (3),
    .DEB_CYCLES   (2),
    .SCAN_DIV     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         adv;
    logic       rst;
    logic       ss;
    logic       stp;
    logic       dir;
    logic       clr;
    logic [7:0] count;
    logic       running;
    logic       tick;
    logic       chk_disp;
    logic [1:0] sel;
    logic [3:0] digit;
  } vec_t;

  vec_t sb[$];

  function automatic vec_t mk(string name, int adv, logic ss, logic stp, logic dir, logic clr,
                              logic [7:0] count, logic running, logic tick);
    vec_t v;
    v.name = name; v.adv = adv; v.rst = 1'b0;
    v.ss = ss; v.stp = stp; v.dir = dir; v.clr = clr;
    v.count = count; v.running = running; v.tick = tick;
    v.chk_disp = 1'b0; v.sel = 2'b01; v.digit = 4'h0;
    return v;
  endfunction

  function automatic vec_t mk_rst(string name, int adv);
    vec_t v;
    v = mk(name, adv, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    v.rst = 1'b1; v.chk_disp = 1'b1; v.sel = 2'b01; v.digit = 4'h0;
    return v;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) since_rst = 0;
      else     since_rst++;
      #1;
    end
  endtask

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: empty at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".count"},   bus.count,          e.count);
      cmp({e.name, ".running"}, {7'd0, bus.running}, {7'd0, e.running});
      cmp({e.name, ".tick"},    {7'd0, bus.tick},    {7'd0, e.tick});
      if (e.chk_disp) begin
        cmp({e.name, ".digit_sel"}, {6'd0, bus.digit_sel}, {6'd0, e.sel});
        cmp({e.name, ".digit"},     {4'd0, bus.digit},     {4'd0, e.digit});
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    rst                = v.rst;
    bus.btn_start_stop = v.ss;
    bus.btn_step       = v.stp;
    bus.dir            = v.dir;
    bus.clr            = v.clr;
    sb.push_back(v);
    tick_n(v.adv);
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       t2 [12];
    vec_t       v;
    logic [5:0] bounce;

    tests = 0; fails = 0; since_rst = 0;
    rst = 1'b1;
    bus.btn_start_stop = 1'b0; bus.btn_step = 1'b0; bus.dir = 1'b0; bus.clr = 1'b0;

    // Start press held 12 samples, run, then a second press stops at 05.
    t2[0]  = mk("run_pre",    5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    t2[1]  = mk("run_rise",   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    t2[2]  = mk("run_tick0",  3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    t2[3]  = mk("run_inc1",   1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
    t2[4]  = mk("run_hold",   2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
    t2[5]  = mk("run_tick1",  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1);
    t2[6]  = mk("run_inc2",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
    t2[7]  = mk("run_inc4",   8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0);
    t2[8]  = mk("stop_press", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
    t2[9]  = mk("stop_rel",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
    t2[10] = mk("stop_fall",  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
    t2[11] = mk("stop_hold",  8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);

    run_vec(mk_rst("reset", 2));
    for (int i = 0; i < 12; i++) run_vec(t2[i]);

    // Short bounces on the step button must be ignored.
    bounce = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      bus.btn_step = bounce[i];
      tick_n(1);
    end
    run_vec(mk("bounce",     8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0));
    run_vec(mk("clr_idle",   1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0));
    run_vec(mk("step_press", 4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    run_vec(mk("step_wait",  2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0));
    run_vec(mk("step_upd",   1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("step_once",  7, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0));

    // Step down to FE, then run up across the FF boundary.
    run_vec(mk("fe_press",   4, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("fe_wait",    2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("fe_upd",     1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0));
    run_vec(mk("fe_settle",  5, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0));
    run_vec(mk("wrap_press", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0));
    run_vec(mk("wrap_rel",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0));
    run_vec(mk("wrap_run",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0));
    run_vec(mk("wrap_tick1", 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1));
    run_vec(mk("wrap_ff",    1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0));
    run_vec(mk("wrap_tick2", 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1));
`ifdef COUNT_AUTOSTOP_EN
    run_vec(mk("autostop",      1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("restart_press", 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("restart_rel",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
    run_vec(mk("restart_run",   1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0));
    run_vec(mk("restart_tick",  3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1));
    run_vec(mk("restart_stop",  1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0));
`else
    run_vec(mk("wrap_00",    1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0));
`endif

    // clr coinciding with a tick at count 10 while running.
    run_vec(mk_rst("reset2", 1));
    run_vec(mk("clr_start", 4,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    run_vec(mk("clr_at10",  69, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1));
    run_vec(mk("clr_hit",   1,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0));
    run_vec(mk("clr_tick",  3,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1));
    run_vec(mk("clr_inc",   1,  1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0));
    run_vec(mk("clr_at05",  16, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0));

    // Reset while running.
    run_vec(mk_rst("reset_run", 1));
    run_vec(mk("post_reset", 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));

    // Run up to 3A, stop, then watch the digit scan.
    run_vec(mk("scan_start",   4,   1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    run_vec(mk("scan_run",     230, 1'b0, 1'b0, 1'b0, 1'b0, 8'h39, 1'b1, 1'b0));
    run_vec(mk("scan_stop",    4,   1'b1, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b1, 1'b0));
    run_vec(mk("scan_stopped", 2,   1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0));
    while ((since_rst % 8) != 0) tick_n(1);
    for (int i = 0; i < 16; i++) begin
      v = mk("scan", (i == 0) ? 0 : 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0);
      v.chk_disp = 1'b1;
      v.sel      = ((i % 8) < 4) ? 2'b01 : 2'b10;
      v.digit    = ((i % 8) < 4) ? 4'hA  : 4'h3;
      run_vec(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
